// File: rtl/sm_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// master = the loader; slave = the byte source / memory side.
interface sm_imem_loader_if #(
   parameter int NODE_CNT = 16,
   parameter int AW       = 7
);
   // Stream handshake: a byte transfers in every cycle where in_valid && in_ready.
   // The loader holds in_ready at 1, so every valid byte is consumed in its cycle.
   logic                in_valid;
   logic [7:0]          in_data;
   logic                in_ready;
   logic                imem_we;
   logic [NODE_CNT-1:0] imem_sel;
   logic [AW-1:0]       imem_addr;
   logic [31:0]         imem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_sel, imem_addr, imem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_sel, imem_addr, imem_wdata
   );
endinterface

// File: rtl/sm_imem_loader.sv
// Boot loader: parses A5/NODE/CNT/DATA/CSUM frames from a byte stream and
// writes little-endian words into the selected node instruction memories.
module sm_imem_loader #(
   parameter int SIZE          = 128,
   parameter int NODE_CNT      = 16,
   parameter int TIMEOUT       = 65535,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   sm_imem_loader_if.master bus,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [2:0]       dbg_state
);
   localparam int AW = $clog2(SIZE);
   localparam int IW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_NODE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_ERR
   } state_t;

   state_t              r_state, w_state_nx;
   logic [7:0]          r_xor, r_cnt_lo;
   logic [IW-1:0]       r_cnt, r_widx;
   logic [1:0]          r_bidx, r_code_pend, r_code, w_code_nx;
   logic [23:0]         r_word;
   logic [TW-1:0]       r_idle;
   logic                r_we, r_hold, r_done, r_err;
   logic [NODE_CNT-1:0] r_sel, w_sel_onehot;
   logic [AW-1:0]       r_addr;
   logic [31:0]         r_wdata;
   logic                w_tmo, w_byte, w_node_uni, w_node_bc, w_last_word;
   logic [15:0]         w_count;

   // A timeout in the same cycle as a byte wins; that byte is dropped.
   assign w_tmo        = (r_state != S_IDLE) && (r_state != S_ERR) && (r_idle == TW'(TIMEOUT));
   assign w_byte       = bus.in_valid && !w_tmo;
   assign w_node_uni   = int'(bus.in_data) < NODE_CNT;
   assign w_node_bc    = bus.in_data == 8'hFF;
   assign w_count      = {bus.in_data, r_cnt_lo};
   assign w_last_word  = (r_bidx == 2'd3) && ((r_widx + IW'(1)) == r_cnt);
   assign w_sel_onehot = NODE_CNT'(1) << bus.in_data;

   always_comb begin
      w_state_nx = r_state;
      w_code_nx  = r_code_pend;
      if (r_state == S_ERR) begin
         w_state_nx = S_IDLE;
      end else if (w_tmo) begin
         w_state_nx = S_ERR;
         w_code_nx  = 2'd3;
      end else if (w_byte) begin
         case (r_state)
            S_IDLE:   if (bus.in_data == 8'hA5) w_state_nx = S_NODE;
            S_NODE: begin
               if (w_node_uni || w_node_bc) begin
                  w_state_nx = S_CNT_LO;
               end else begin
                  w_state_nx = S_ERR;
                  w_code_nx  = 2'd0;
               end
            end
            S_CNT_LO: w_state_nx = S_CNT_HI;
            S_CNT_HI: begin
               if (int'(w_count) > SIZE) begin
                  w_state_nx = S_ERR;
                  w_code_nx  = 2'd1;
               end else if (w_count == 16'd0) begin
                  w_state_nx = S_CSUM;
               end else begin
                  w_state_nx = S_DATA;
               end
            end
            S_DATA:   if (w_last_word) w_state_nx = S_CSUM;
            S_CSUM: begin
               if (bus.in_data == r_xor) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_ERR;
                  w_code_nx  = 2'd2;
               end
            end
            default:  w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xor <= '0; r_cnt_lo <= '0; r_cnt <= '0; r_widx <= '0; r_bidx <= '0;
         r_code_pend <= '0; r_code <= '0; r_word <= '0; r_idle <= '0;
         r_we <= 1'b0; r_hold <= HOLD_AT_RESET; r_done <= 1'b0; r_err <= 1'b0;
         r_sel <= '0; r_addr <= '0; r_wdata <= '0;
      end else begin
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         r_code_pend <= w_code_nx;
         if (r_state == S_IDLE || r_state == S_ERR || w_byte) r_idle <= '0;
         else if (r_idle != TW'(TIMEOUT))                    r_idle <= r_idle + TW'(1);
         if (r_state == S_ERR) begin
            r_err  <= 1'b1;
            r_code <= r_code_pend;
         end
         if (w_byte) begin
            case (r_state)
               S_IDLE: begin
                  if (bus.in_data == 8'hA5) begin
                     r_hold <= 1'b1; r_err <= 1'b0; r_code <= 2'd0;
                     r_xor  <= '0;   r_widx <= '0;  r_bidx <= '0;
                  end
               end
               S_NODE: begin
                  r_xor <= r_xor ^ bus.in_data;
                  if (w_node_uni)     r_sel <= w_sel_onehot;
                  else if (w_node_bc) r_sel <= '1;
               end
               S_CNT_LO: begin
                  r_xor    <= r_xor ^ bus.in_data;
                  r_cnt_lo <= bus.in_data;
               end
               S_CNT_HI: begin
                  r_xor <= r_xor ^ bus.in_data;
                  r_cnt <= w_count[IW-1:0];
               end
               S_DATA: begin
                  r_xor  <= r_xor ^ bus.in_data;
                  r_bidx <= r_bidx + 2'd1;
                  case (r_bidx)
                     2'd0: r_word[7:0]   <= bus.in_data;
                     2'd1: r_word[15:8]  <= bus.in_data;
                     2'd2: r_word[23:16] <= bus.in_data;
                     default: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_widx[AW-1:0];
                        r_wdata <= {bus.in_data, r_word};
                        r_widx  <= r_widx + IW'(1);
                     end
                  endcase
               end
               S_CSUM: begin
                  if (bus.in_data == r_xor) begin
                     r_done <= 1'b1;
                     r_hold <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready   = 1'b1;
   assign bus.imem_we    = r_we;
   assign bus.imem_sel   = r_sel;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign cpu_hold       = r_hold;
   assign busy           = r_state != S_IDLE;
   assign done           = r_done;
   assign err            = r_err;
   assign err_code       = r_code;
   assign dbg_state      = r_state;
endmodule
